// File: rtl/wb_regfile.sv
// Writeback pipeline register and 32x32 register file with two forwarding read ports.
// wb_* update one edge after ex_*, commit lands one edge later; stall_i holds, flush_i bubbles.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] ex_wd_i,
  input  logic              ex_wreg_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [ADDR_W-1:0] wb_wd_o,
  output logic              wb_wreg_o,
  output logic [DATA_W-1:0] wb_wdata_o
);

  logic [ADDR_W-1:0] r_wb_wd;
  logic              r_wb_wreg;
  logic [DATA_W-1:0] r_wb_wdata;
  logic [DATA_W-1:0] r_regs [NREG];
  logic              w_commit;

  assign wb_wd_o    = r_wb_wd;
  assign wb_wreg_o  = r_wb_wreg;
  assign wb_wdata_o = r_wb_wdata;

  assign w_commit = r_wb_wreg && (r_wb_wd != '0);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_wb_wd    <= '0;
      r_wb_wreg  <= 1'b0;
      r_wb_wdata <= '0;
    end else if (!stall_i) begin
      r_wb_wd    <= ex_wd_i;
      r_wb_wreg  <= ex_wreg_i;
      r_wb_wdata <= ex_wdata_i;
    end
  end

  // A held (stalled) entry keeps re-committing the same value; harmless by design.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      r_regs[r_wb_wd] <= r_wb_wdata;
    end
  end

  function automatic logic [DATA_W-1:0] f_read(
    input logic              rst_v,
    input logic              re,
    input logic [ADDR_W-1:0] ra,
    input logic              exw,
    input logic [ADDR_W-1:0] exd,
    input logic [DATA_W-1:0] exdat,
    input logic              wbw,
    input logic [ADDR_W-1:0] wbd,
    input logic [DATA_W-1:0] wbdat,
    input logic [DATA_W-1:0] arr
  );
    logic [DATA_W-1:0] v;
    if (rst_v || !re || ra == '0) v = '0;
    else if (exw && exd == ra)    v = exdat;
    else if (wbw && wbd == ra)    v = wbdat;
    else                          v = arr;
    return v;
  endfunction

  always_comb begin
    rdata1_o = '0;
    rdata1_o = f_read(rst, re1_i, raddr1_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                      r_wb_wreg, r_wb_wd, r_wb_wdata, r_regs[raddr1_i]);
  end

  always_comb begin
    rdata2_o = '0;
    rdata2_o = f_read(rst, re2_i, raddr2_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                      r_wb_wreg, r_wb_wd, r_wb_wdata, r_regs[raddr2_i]);
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage plus general-purpose register file; the consuming end of the execute-stage result bus (destination address, write enable, result data). It registers each execute result in a one-deep writeback pipeline register and commits it to a 32 x 32-bit register file one cycle later. It serves the decode stage through two combinational read ports with a forwarding network, so a dependent instruction sees the newest value without stalling.

## Interface

Parameters:
- DATA_W, 32, register and result width
- ADDR_W, 5, register address width
- NREG, 32, number of architectural registers (2**ADDR_W); register 0 is hard-wired zero

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- stall_i  in  1  hold the writeback pipeline register
- flush_i  in  1  load a bubble into the writeback pipeline register
- ex_wd_i  in  ADDR_W  execute-stage destination register
- ex_wreg_i  in  1  execute-stage write enable
- ex_wdata_i  in  DATA_W  execute-stage result
- re1_i  in  1  read-port-1 enable
- raddr1_i  in  ADDR_W  read-port-1 address
- rdata1_o  out  DATA_W  read-port-1 data (combinational)
- re2_i  in  1  read-port-2 enable
- raddr2_i  in  ADDR_W  read-port-2 address
- rdata2_o  out  DATA_W  read-port-2 data (combinational)
- wb_wd_o  out  ADDR_W  writeback pipeline register: destination
- wb_wreg_o  out  1  writeback pipeline register: write enable
- wb_wdata_o  out  DATA_W  writeback pipeline register: data

## Operation

Writeback pipeline register:
- Each rising edge, priority is rst > flush_i > stall_i > capture.
- On rst or flush_i, wb_wd_o, wb_wreg_o and wb_wdata_o are all loaded with 0.
- On stall_i, all three hold their values.
- Otherwise, wb_* are loaded from ex_*.

Register file commit:
- Each rising edge with rst=0, if wb_wreg_o=1 and wb_wd_o≠0, then regs[wb_wd_o] ← wb_wdata_o.
- A stalled entry re-commits the same value each cycle. This is idempotent and is required behaviour.
- On rst, all NREG registers are cleared to 0, and no commit takes place that edge.
- Writes to register 0 are discarded. A read of register 0 always returns 0.

Read port n (identical for n=1,2), first matching rule wins:
1. rst=1 → 0
2. re_n=0 → 0
3. raddr_n=0 → 0
4. ex_wreg_i=1 and ex_wd_i=raddr_n → ex_wdata_i (newest result)
5. wb_wreg_o=1 and wb_wd_o=raddr_n → wb_wdata_o (committing this edge)
6. otherwise → regs[raddr_n]

Forwarding rule 4 applies regardless of stall_i and flush_i. Masking a squashed execute result is the hazard unit's responsibility, done by deasserting ex_wreg_i.

Both ports may read the same address in the same cycle, and both return the same value.

## Timing

- Reset values: wb_wd_o=0, wb_wreg_o=0, wb_wdata_o=0, all regs=0. rdata1_o and rdata2_o are 0 while rst=1.
- The pipeline register has 1-cycle latency: ex_* sampled at edge N appear on wb_* after edge N.
- The register file commits at edge N+1, and the value is visible from the array after edge N+1.
- Read-after-write needs 0 bubbles. The value is available via rule 4 in cycle N, via rule 5 in cycle N+1, and via the array from cycle N+2.
- Back-to-back writes to the same register resolve to the newest: rule 4 beats rule 5, and the later commit overwrites the earlier one.
- When flush_i and stall_i are both high, flush wins.
- When rst is asserted mid-stream, any in-flight wb_* entry is discarded and not committed.
- No combinational path from rdata_n to any sequential element inside the block.

## Test plan

- Reset: hold rst 2 cycles after writing random data. All wb_* read 0, and reading r1..r31 on both ports returns 0.
- Commit path: ex_wd_i=5, ex_wreg_i=1, ex_wdata_i=0xDEADBEEF for one cycle, then ex_wreg_i=0, with port 1 reading r5 throughout. rdata1_o=0xDEADBEEF in cycle N (rule 4), in cycle N+1 (rule 5), and from cycle N+2 onward (array).
- Newest wins: write r7=0x11111111, then r7=0x22222222 the next cycle, reading r7 on both ports. Both ports read 0x22222222 from the second cycle onward, and never 0x11111111 after it.
- Register 0: ex_wd_i=0, ex_wreg_i=1, ex_wdata_i=0xFFFFFFFF. rdata for address 0 stays 0, wb_wd_o=0, and no register changes.
- Stall/flush: capture r3=0xA5A5A5A5, then assert stall_i for 3 cycles while ex_* changes. wb_* stay at 3/1/0xA5A5A5A5. Then assert stall_i and flush_i together. wb_* go to 0/0/0, and r3 holds 0xA5A5A5A5.
- Read enables: re1_i=0 with raddr1_i=3 (r3 holding 0xA5A5A5A5) gives rdata1_o=0, while port 2 with re2_i=1 on r3 returns 0xA5A5A5A5.
